// File: rtl/ace_access_arbiter.sv
// Arbitrates one shared line/memory access port among ACE snoop (AC), AXI write (AW) and AXI read (AR).
// Latency: handshake in T -> one-hot grant T+1..T+ACCESS_CYCLES; snoop response earliest T+ACCESS_CYCLES+1.
// Backpressure: a single request is accepted only in IDLE; the CR response is held until crready.
module ace_access_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic acvalid,
    input  logic acsnoop,
    output logic acready,
    input  logic awvalid,
    output logic awready,
    input  logic arvalid,
    output logic arready,
    input  logic line_dirty,
    output logic crvalid,
    input  logic crready,
    output logic crresp_dirty,
    output logic gnt_snoop,
    output logic gnt_write,
    output logic gnt_read,
    output logic snoop_type,
    output logic busy
);

    localparam int CW = ($clog2(ACCESS_CYCLES + 1) < 1) ? 1 : $clog2(ACCESS_CYCLES + 1);
    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCESS     = 2'd1,
        SNOOP_RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   starve_cnt;
    logic            rr_ptr;
    logic            snoop_type_q;
    logic            dirty_q;

    logic            rr_aw;
    logic            rr_ar;
    logic            forced;
    logic            sel_ac;
    logic            sel_aw;
    logic            sel_ar;
    logic            hs_ac;
    logic            hs_aw;
    logic            hs_ar;
    logic            hs_any;

    // Request selection; once snoops have starved AW/AR long enough, AC is ignored for one pick.
    always_comb begin
        rr_aw  = awvalid & (~arvalid | ~rr_ptr);
        rr_ar  = arvalid & ~rr_aw;
        forced = (starve_cnt == SW'(STARVE_LIMIT)) & (awvalid | arvalid);
        sel_ac = acvalid & ~forced;
        sel_aw = ~sel_ac & rr_aw;
        sel_ar = ~sel_ac & rr_ar;
    end

    // Ready is gated by rst_n so it drops the instant reset asserts.
    assign acready = rst_n & (state == IDLE) & sel_ac;
    assign awready = rst_n & (state == IDLE) & sel_aw;
    assign arready = rst_n & (state == IDLE) & sel_ar;

    assign hs_ac  = acvalid & acready;
    assign hs_aw  = awvalid & awready;
    assign hs_ar  = arvalid & arready;
    assign hs_any = hs_ac | hs_aw | hs_ar;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (hs_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = gnt_snoop ? SNOOP_RESP : IDLE;
                end
            end
            SNOOP_RESP: begin
                if (crready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_snoop    <= 1'b0;
            gnt_write    <= 1'b0;
            gnt_read     <= 1'b0;
            cnt          <= '0;
            snoop_type_q <= 1'b0;
            dirty_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs_any) begin
                        gnt_snoop <= hs_ac;
                        gnt_write <= hs_aw;
                        gnt_read  <= hs_ar;
                        cnt       <= CW'(ACCESS_CYCLES - 1);
                    end
                    if (hs_ac) begin
                        snoop_type_q <= acsnoop;
                        dirty_q      <= line_dirty;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        gnt_snoop <= 1'b0;
                        gnt_write <= 1'b0;
                        gnt_read  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SNOOP_RESP: begin
                    if (crready) begin
                        dirty_q <= 1'b0;
                    end
                end
                default: begin
                    gnt_snoop <= 1'b0;
                    gnt_write <= 1'b0;
                    gnt_read  <= 1'b0;
                end
            endcase
        end
    end

    // Fairness state: round-robin pointer between AW/AR and snoop starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            if (hs_aw) begin
                rr_ptr <= 1'b1;
            end else if (hs_ar) begin
                rr_ptr <= 1'b0;
            end

            if (hs_aw | hs_ar) begin
                starve_cnt <= '0;
            end else if (hs_ac & (awvalid | arvalid) & (starve_cnt != SW'(STARVE_LIMIT))) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

    assign crvalid      = (state == SNOOP_RESP);
    assign crresp_dirty = crvalid & dirty_q;
    assign snoop_type   = gnt_snoop & snoop_type_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_ace_access_arbiter.sv
// Directed bench for ace_access_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_ace_access_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic acvalid = 1'b0, acsnoop = 1'b0, awvalid = 1'b0, arvalid = 1'b0;
    logic line_dirty = 1'b0, crready = 1'b0;
    logic acready, awready, arready, crvalid, crresp_dirty;
    logic gnt_snoop, gnt_write, gnt_read, snoop_type, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ace_access_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .acvalid(acvalid), .acsnoop(acsnoop), .acready(acready),
        .awvalid(awvalid), .awready(awready),
        .arvalid(arvalid), .arready(arready),
        .line_dirty(line_dirty),
        .crvalid(crvalid), .crready(crready), .crresp_dirty(crresp_dirty),
        .gnt_snoop(gnt_snoop), .gnt_write(gnt_write), .gnt_read(gnt_read),
        .snoop_type(snoop_type), .busy(busy)
    );

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        acvalid = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
        acsnoop = 1'b0; line_dirty = 1'b0; crready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s idle timeout: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        acvalid = 1'b1; awvalid = 1'b1; arvalid = 1'b1;
        #1;
        tests++;
        if ({acready, awready, arready, gnt_snoop, gnt_write, gnt_read, crvalid, crresp_dirty, snoop_type, busy} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 0", {acready, awready, arready, gnt_snoop, gnt_write, gnt_read, crvalid, crresp_dirty, snoop_type, busy});
        end
        tests++;
        if ({dut.state, dut.rr_ptr, dut.starve_cnt, dut.cnt} !== 8'b0) begin
            fails++;
            $display("FAIL reset_state: got %b required 0", {dut.state, dut.rr_ptr, dut.starve_cnt, dut.cnt});
        end
        @(negedge clk);
        acvalid = 1'b0; awvalid = 1'b0; arvalid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_write_alone;
        @(negedge clk); awvalid = 1'b1; #1;
        tests++;
        if ({acready, awready, arready} !== 3'b010) begin
            fails++; $display("FAIL write_ready: got %b required 010", {acready, awready, arready});
        end
        @(negedge clk); awvalid = 1'b0; #1;
        tests++;
        if ({gnt_snoop, gnt_write, gnt_read, busy} !== 4'b0101) begin
            fails++; $display("FAIL write_grant_c1: got %b required 0101", {gnt_snoop, gnt_write, gnt_read, busy});
        end
        @(negedge clk); #1;
        tests++;
        if ({gnt_snoop, gnt_write, gnt_read, busy} !== 4'b0101) begin
            fails++; $display("FAIL write_grant_c2: got %b required 0101", {gnt_snoop, gnt_write, gnt_read, busy});
        end
        @(negedge clk); awvalid = 1'b1; #1;
        tests++;
        if ({gnt_write, busy, awready} !== 3'b001) begin
            fails++; $display("FAIL write_back_to_back: got %b required 001", {gnt_write, busy, awready});
        end
        @(negedge clk); awvalid = 1'b0; #1;
        tests++;
        if (gnt_write !== 1'b1) begin
            fails++; $display("FAIL write2_grant: got %b required 1", gnt_write);
        end
        wait_idle("write2");
    endtask

    task automatic test_snoop;
        @(negedge clk); acvalid = 1'b1; acsnoop = 1'b1; line_dirty = 1'b1; crready = 1'b0; #1;
        tests++;
        if ({acready, awready, arready} !== 3'b100) begin
            fails++; $display("FAIL snoop_ready: got %b required 100", {acready, awready, arready});
        end
        @(negedge clk); acvalid = 1'b0; acsnoop = 1'b0; line_dirty = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if ({gnt_snoop, gnt_write, gnt_read, snoop_type, crvalid, busy} !== 6'b100101) begin
                fails++; $display("FAIL snoop_grant c%0d: got %b required 100101", i, {gnt_snoop, gnt_write, gnt_read, snoop_type, crvalid, busy});
            end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) acvalid = 1'b1;
            if (i == 2) acvalid = 1'b0;
            #1;
            tests++;
            if ({gnt_snoop, crvalid, crresp_dirty, acready, busy} !== 5'b01101) begin
                fails++; $display("FAIL snoop_resp_hold c%0d: got %b required 01101", i, {gnt_snoop, crvalid, crresp_dirty, acready, busy});
            end
            if (i == 2) crready = 1'b1;
            @(negedge clk);
        end
        crready = 1'b0; #1;
        tests++;
        if ({crvalid, crresp_dirty, busy} !== 3'b000) begin
            fails++; $display("FAIL snoop_resp_done: got %b required 000", {crvalid, crresp_dirty, busy});
        end
    endtask

    task automatic test_round_robin;
        logic exp_w;
        @(negedge clk); awvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = (i % 2 == 0);
            #1;
            tests++;
            if ({acready, awready, arready} !== {1'b0, exp_w, ~exp_w}) begin
                fails++; $display("FAIL rr_ready %0d: got %b required %b", i, {acready, awready, arready}, {1'b0, exp_w, ~exp_w});
            end
            for (int c = 0; c < 2; c++) begin
                @(negedge clk); #1;
                tests++;
                if ({gnt_write, gnt_read, awready, arready} !== {exp_w, ~exp_w, 2'b00}) begin
                    fails++; $display("FAIL rr_grant %0d.%0d: got %b required %b", i, c, {gnt_write, gnt_read, awready, arready}, {exp_w, ~exp_w, 2'b00});
                end
            end
            @(negedge clk);
        end
        awvalid = 1'b0; arvalid = 1'b0;
        wait_idle("round_robin");
    endtask

    task automatic test_starvation;
        logic [5:0] exp_snoop;
        logic [2:0] exp_cnt [6];
        int k = 0;
        exp_snoop = 6'b101111;
        exp_cnt = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        @(negedge clk); acvalid = 1'b1; arvalid = 1'b1; crready = 1'b1;
        for (int c = 0; c < 60 && k < 6; c++) begin
            #1;
            if (acready | arready) begin
                tests++;
                if ({acready, arready} !== {exp_snoop[k], ~exp_snoop[k]}) begin
                    fails++; $display("FAIL starve_order %0d: got %b required %b", k, {acready, arready}, {exp_snoop[k], ~exp_snoop[k]});
                end
                tests++;
                if (dut.starve_cnt !== exp_cnt[k]) begin
                    fails++; $display("FAIL starve_cnt %0d: got %0d required %0d", k, dut.starve_cnt, exp_cnt[k]);
                end
                k++;
            end
            @(negedge clk);
        end
        acvalid = 1'b0; arvalid = 1'b0;
        tests++;
        if (k != 6) begin
            fails++; $display("FAIL starve_timeout: got %0d handshakes required 6", k);
        end
        wait_idle("starvation");
        crready = 1'b0;
    endtask

    task automatic test_priority;
        @(negedge clk); acvalid = 1'b1; awvalid = 1'b1; arvalid = 1'b1; acsnoop = 1'b0; crready = 1'b1; #1;
        tests++;
        if ({acready, awready, arready} !== 3'b100) begin
            fails++; $display("FAIL prio_ready: got %b required 100", {acready, awready, arready});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            tests++;
            if ({gnt_snoop, snoop_type, crvalid, crresp_dirty, acready, awready, arready} !== {(c < 2), 1'b0, (c == 2), 4'b0000}) begin
                fails++; $display("FAIL prio_hold c%0d: got %b required %b", c, {gnt_snoop, snoop_type, crvalid, crresp_dirty, acready, awready, arready}, {(c < 2), 1'b0, (c == 2), 4'b0000});
            end
        end
        @(negedge clk); acvalid = 1'b0; #1;
        tests++;
        if ({busy, acready, awready, arready} !== 4'b0010) begin
            fails++; $display("FAIL prio_after: got %b required 0010", {busy, acready, awready, arready});
        end
        @(negedge clk); awvalid = 1'b0; arvalid = 1'b0; crready = 1'b0; #1;
        tests++;
        if (gnt_write !== 1'b1) begin
            fails++; $display("FAIL prio_write_grant: got %b required 1", gnt_write);
        end
        wait_idle("priority");
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk); awvalid = 1'b1; #1;
        tests++;
        if (awready !== 1'b1) begin
            fails++; $display("FAIL mid_ready: got %b required 1", awready);
        end
        @(negedge clk); awvalid = 1'b0;
        @(negedge clk); #1;
        tests++;
        if (gnt_write !== 1'b1) begin
            fails++; $display("FAIL mid_grant_c2: got %b required 1", gnt_write);
        end
        rst_n = 1'b0; #1;
        tests++;
        if ({gnt_snoop, gnt_write, gnt_read, crvalid, busy} !== 5'b0) begin
            fails++; $display("FAIL mid_async_drop: got %b required 0", {gnt_snoop, gnt_write, gnt_read, crvalid, busy});
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++;
        if ({dut.state, dut.rr_ptr, dut.starve_cnt, busy} !== 7'b0) begin
            fails++; $display("FAIL mid_after_release: got %b required 0", {dut.state, dut.rr_ptr, dut.starve_cnt, busy});
        end
    endtask

    initial begin
        test_reset;
        test_write_alone;
        test_snoop;
        do_reset;
        test_round_robin;
        do_reset;
        test_starvation;
        do_reset;
        test_priority;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ace_access_arbiter.md
Name: ace_access_arbiter

Overview:
- Arbitrates one shared cache-line/memory access port among three requesters: ACE snoop (AC), AXI write (AW) and AXI read (AR).
- Accepts exactly one request per access, holds a one-hot grant for a fixed access window, and returns a snoop response (CR channel) for snoops.
- Sits in front of the per-line coherence state FSM and the memory port.
- Its grants and latched snoop type drive that FSM's valid/snoop inputs; the FSM's dirty indication feeds back as `line_dirty`.

Parameters:
- ACCESS_CYCLES, 2, cycles a grant is held per access; legal range ≥1.
- STARVE_LIMIT, 4, consecutive snoop grants taken while AW/AR is pending before one AW/AR access is forced ahead of snoops; legal range ≥1.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- acvalid  input  1  snoop request valid
- acsnoop  input  1  snoop type (1 = clean, 0 = invalidate)
- acready  output  1  snoop request accepted
- awvalid  input  1  write request valid
- awready  output  1  write request accepted
- arvalid  input  1  read request valid
- arready  output  1  read request accepted
- line_dirty  input  1  current line is UniqueDirty (from the coherence FSM)
- crvalid  output  1  snoop response valid
- crready  input  1  snoop response accepted
- crresp_dirty  output  1  line was dirty when the snoop was accepted
- gnt_snoop  output  1  snoop owns the port
- gnt_write  output  1  write owns the port
- gnt_read  output  1  read owns the port
- snoop_type  output  1  latched acsnoop; valid while gnt_snoop=1
- busy  output  1  state ≠ IDLE

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- Reset values:
  - state = IDLE, all outputs 0.
  - rr_ptr = 0 (write favoured), starve_cnt = 0, cnt = 0.
- States: IDLE, ACCESS, SNOOP_RESP; unused encodings → IDLE.
- IDLE, selection (combinational, same cycle):
  - Forced case: if starve_cnt == STARVE_LIMIT and (awvalid or arvalid), choose between AW and AR by round-robin, ignoring acvalid.
  - Otherwise: acvalid first, then AW/AR by round-robin.
  - Round-robin: rr_ptr=0 prefers AW, rr_ptr=1 prefers AR; the lone requester wins if only one is valid.
- IDLE, handshake:
  - Only the selected channel's ready is asserted, so at most one of acready/awready/arready is high in any cycle.
  - Ready is asserted only when the matching valid is high; ready is 0 outside IDLE.
  - A handshake (valid & ready) moves the FSM to ACCESS and registers the one-hot grant.
  - cnt loads ACCESS_CYCLES-1. cnt width = $clog2(ACCESS_CYCLES+1), minimum 1.
  - On a snoop handshake, also latch snoop_type ← acsnoop and crresp_dirty ← line_dirty.
- ACCESS:
  - The grant is held for exactly ACCESS_CYCLES cycles; cnt decrements each cycle.
  - At cnt == 0: go to SNOOP_RESP if gnt_snoop, else IDLE. All grants drop on that transition.
- SNOOP_RESP:
  - crvalid=1 and crresp_dirty stays stable until crready.
  - On crvalid & crready: go to IDLE next cycle; crvalid and crresp_dirty drop to 0.
  - No new request is accepted until IDLE.
- Latency:
  - Handshake in cycle T → grant high T+1 … T+ACCESS_CYCLES.
  - Write/read: earliest next handshake T+ACCESS_CYCLES+1.
  - Snoop: crvalid earliest T+ACCESS_CYCLES+1.
- rr_ptr updates on handshake only: AW grant → 1, AR grant → 0; snoop grants leave it unchanged.
- starve_cnt:
  - On a snoop handshake while awvalid or arvalid: increment, saturating at STARVE_LIMIT.
  - On an AW/AR handshake: clear to 0.
  - Otherwise hold.
- Simultaneous events:
  - All three valid, starve_cnt < limit → snoop wins.
  - All three valid, starve_cnt == limit → AW/AR wins by rr_ptr.
  - A valid dropped before the handshake is not an error; no handshake occurs and the FSM stays in IDLE.
- Reset mid-operation (ACCESS or SNOOP_RESP): grants, crvalid and ready drop immediately (asynchronously); the access is abandoned with no response.
- Invariants: gnt_* are one-hot-or-zero; busy = gnt_snoop | gnt_write | gnt_read | crvalid.

Test Plan (ACCESS_CYCLES=2, STARVE_LIMIT=4 unless noted):
- Write alone: awvalid=1 at cycle 5 → awready=1 at 5; gnt_write=1 at cycles 6–7; busy=0 at 8; a second awvalid at 8 → awready=1 at 8.
- Snoop, clean, line dirty, crready held 0 for 3 cycles: acvalid=1, acsnoop=1, line_dirty=1 at cycle 5 → acready at 5; gnt_snoop and snoop_type=1 at 6–7; crvalid=1, crresp_dirty=1 from 8 until crready; IDLE the cycle after crready.
- Round-robin: awvalid and arvalid held high continuously → grants alternate W, R, W, R, starting with W after reset; each window is 2 cycles followed by 1 IDLE cycle.
- Starvation: acvalid and arvalid held high, crready=1 → exactly 4 snoop accesses, then 1 read access, then snoops resume; starve_cnt goes 0→4→0.
- Priority collision: acvalid, awvalid and arvalid all rise in the same cycle with starve_cnt=0 → only acready=1; awready=arready=0 until IDLE returns.
- Reset mid-access: rst_n low during cycle 2 of a write grant → gnt_write=0 and busy=0 immediately; after release, state is IDLE, rr_ptr=0, starve_cnt=0.
